// File: rtl/sar_sequencer_if.sv
// Result bus from the SAR sequencer to the readout path: FIFO head entry plus valid/ready.
interface sar_sequencer_if #(
    parameter int Ndac = 16
);
    logic [Ndac-1:0] res_data;
    logic [7:0]      res_tag;
    logic            res_valid;
    logic            res_ready;

    modport master (output res_data, res_tag, res_valid, input res_ready);
    modport slave  (input res_data, res_tag, res_valid, output res_ready);
endinterface

// File: rtl/sar_sequencer.sv
// SAR conversion sequencer: registered clk_init/clk_update strobes, captures the final code into a FWFT FIFO.
// Capture lands 2+Ndac*(SETTLE+1) cycles after start; a full FIFO with no pop drops the code and sets overflow.
module sar_sequencer #(
    parameter int Ndac   = 16,
    parameter int SETTLE = 2,
    parameter int DEPTH  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            clear_ovf,
    input  logic [Ndac-1:0] dac_state_in,
    output logic            clk_init,
    output logic            clk_update,
    output logic            busy,
    output logic            overflow,
    sar_sequencer_if.master res
);
    localparam int BW = $clog2(Ndac + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SETTLE,
        S_UPDATE,
        S_CAPTURE
    } state_t;

    typedef struct packed {
        logic [7:0]      tag;
        logic [Ndac-1:0] code;
    } entry_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [SW-1:0]   settle_cnt_q, settle_cnt_d;
    logic            clk_init_q, clk_init_d;
    logic            clk_update_q, clk_update_d;
    logic            busy_q, busy_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      tag_q, tag_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];

    logic            capture;
    logic            pop;
    logic            push;
    logic            drop;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_INIT;
            S_INIT:    state_d = S_SETTLE;
            S_SETTLE:  if (settle_cnt_q == SW'(SETTLE - 1)) state_d = S_UPDATE;
            S_UPDATE:  state_d = (bit_cnt_q == BW'(Ndac - 1)) ? S_CAPTURE : S_SETTLE;
            S_CAPTURE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so the flops show them in the state's own cycle.
    always_comb begin
        clk_init_d   = (state_d == S_INIT);
        clk_update_d = (state_d == S_UPDATE);
        busy_d       = (state_d != S_IDLE);
    end

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        if (state_q == S_INIT) begin
            bit_cnt_d = '0;
        end else if (state_q == S_UPDATE) begin
            bit_cnt_d = bit_cnt_q + BW'(1);
        end

        settle_cnt_d = '0;
        if (state_q == S_SETTLE && settle_cnt_q != SW'(SETTLE - 1)) begin
            settle_cnt_d = settle_cnt_q + SW'(1);
        end
    end

    // A pop in the capture cycle frees the slot, so a full FIFO still takes the new code.
    always_comb begin
        capture = (state_q == S_CAPTURE);
        pop     = (count_q != '0) && res.res_ready;
        push    = capture && ((count_q != CW'(DEPTH)) || pop);
        drop    = capture && !push;

        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        tag_d    = tag_q + 8'(capture);

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{tag: tag_q, code: dac_state_in};
        end

        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q    <= '0;
            settle_cnt_q <= '0;
            clk_init_q   <= 1'b0;
            clk_update_q <= 1'b0;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
            tag_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            clk_init_q   <= clk_init_d;
            clk_update_q <= clk_update_d;
            busy_q       <= busy_d;
            overflow_q   <= overflow_d;
            tag_q        <= tag_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            mem_q        <= mem_d;
        end
    end

    assign clk_init      = clk_init_q;
    assign clk_update    = clk_update_q;
    assign busy          = busy_q;
    assign overflow      = overflow_q;
    assign res.res_data  = mem_q[rd_ptr_q].code;
    assign res.res_tag   = mem_q[rd_ptr_q].tag;
    assign res.res_valid = (count_q != '0);
endmodule

// File: tb/tb_sar_sequencer.sv
// Bench for sar_sequencer: strobe timing from closed-form cycle formulas, results against a queue model.
module tb_sar_sequencer;
    localparam int NDAC   = 16;
    localparam int SETTLE = 2;
    localparam int DEPTH  = 4;
    localparam int CAP    = 2 + NDAC * (SETTLE + 1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            clear_ovf = 1'b0;
    logic [NDAC-1:0] dac_state_in = '0;
    logic            clk_init, clk_update, busy, overflow;

    sar_sequencer_if #(.Ndac(NDAC)) res_if ();

    sar_sequencer #(.Ndac(NDAC), .SETTLE(SETTLE), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .clear_ovf    (clear_ovf),
        .dac_state_in (dac_state_in),
        .clk_init     (clk_init),
        .clk_update   (clk_update),
        .busy         (busy),
        .overflow     (overflow),
        .res          (res_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [23:0] mq[$];
    int          m_tag = 0;
    bit          m_ovf = 1'b0;

    task automatic model_reset();
        mq.delete();
        m_tag = 0;
        m_ovf = 1'b0;
    endtask

    // Applies one clock edge to the model using the inputs about to be sampled.
    task automatic model_edge(input bit cap, input logic [NDAC-1:0] code);
        if (res_if.res_ready === 1'b1 && mq.size() > 0) void'(mq.pop_front());
        if (clear_ovf === 1'b1) m_ovf = 1'b0;
        if (cap) begin
            if (mq.size() < DEPTH) mq.push_back({8'(m_tag), code});
            else m_ovf = 1'b1;
            m_tag = (m_tag + 1) % 256;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        clear_ovf = 1'b0;
        res_if.res_ready = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        int bad = 0;
        logic [23:0] head;
        for (int i = 0; i < n; i++) begin
            model_edge(1'b0, '0);
            @(posedge clk);
            @(negedge clk);
            head = (mq.size() > 0) ? mq[0] : 24'h0;
            if (busy !== 1'b0 || clk_init !== 1'b0 || clk_update !== 1'b0) bad++;
            if (res_if.res_valid !== (mq.size() > 0) || overflow !== m_ovf) bad++;
            if (mq.size() > 0 && {res_if.res_tag, res_if.res_data} !== head) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL idle_cycles: %0d bad cycles, required 0", bad);
        end
    endtask

    // rmode: 0 ready low, 1 high, 2 random, 3 high from the capture cycle.
    // stray: 0 none, 1 pulses at cycles 10 and 30, 2 random, 3 held high.
    task automatic convert(input logic [NDAC-1:0] code, input int rmode, input int stray,
                           input int rst_at, input int clr_at, output int n_upd);
        int bad_init = 0, bad_upd = 0, bad_busy = 0, bad_both = 0, bad_fifo = 0;
        int k;
        bit e_init, e_upd, e_busy;
        logic [23:0] head;
        n_upd = 0;
        start = 1'b1;
        model_edge(1'b0, '0);
        @(posedge clk);
        #1;
        start = (stray == 3);
        for (int c = 1; c <= CAP + 1; c++) begin
            @(negedge clk);
            k = c - 1;
            e_init = (c == 1);
            e_upd  = (k > 0) && (k % (SETTLE + 1) == 0) && (k / (SETTLE + 1) <= NDAC);
            e_busy = (c <= CAP);
            if (clk_init !== e_init) bad_init++;
            if (clk_update !== e_upd) bad_upd++;
            if (busy !== e_busy) bad_busy++;
            if (clk_init === 1'b1 && clk_update === 1'b1) bad_both++;
            if (clk_update === 1'b1) n_upd++;
            head = (mq.size() > 0) ? mq[0] : 24'h0;
            if (res_if.res_valid !== (mq.size() > 0) || overflow !== m_ovf) bad_fifo++;
            if (mq.size() > 0 && {res_if.res_tag, res_if.res_data} !== head) bad_fifo++;
            if (c == CAP + 1) break;
            if (c == rst_at) begin
                rst = 1'b1;
                #1;
                checks++;
                if ({clk_init, clk_update, busy, res_if.res_valid} !== 4'b0000) begin
                    errors++;
                    $display("FAIL reset_mid_drop: init/upd/busy/valid=%b required 0000",
                             {clk_init, clk_update, busy, res_if.res_valid});
                end
                model_reset();
                start = 1'b0;
                clear_ovf = 1'b0;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                break;
            end
            dac_state_in = (c == CAP) ? code : NDAC'($urandom);
            case (stray)
                1:       start = (c == 10 || c == 30);
                2:       start = ($urandom_range(0, 3) == 0);
                3:       start = 1'b1;
                default: start = 1'b0;
            endcase
            case (rmode)
                1:       res_if.res_ready = 1'b1;
                2:       res_if.res_ready = 1'($urandom_range(0, 1));
                3:       res_if.res_ready = (c >= CAP);
                default: res_if.res_ready = 1'b0;
            endcase
            clear_ovf = (c == clr_at);
            model_edge(c == CAP, code);
            @(posedge clk);
        end
        start = 1'b0;
        clear_ovf = 1'b0;
        checks++;
        if (bad_init !== 0) begin
            errors++;
            $display("FAIL conv_clk_init: %0d bad cycles, required 0", bad_init);
        end
        checks++;
        if (bad_upd !== 0) begin
            errors++;
            $display("FAIL conv_clk_update: %0d bad cycles, required 0", bad_upd);
        end
        checks++;
        if (bad_busy !== 0) begin
            errors++;
            $display("FAIL conv_busy: %0d bad cycles, required 0", bad_busy);
        end
        checks++;
        if (bad_both !== 0) begin
            errors++;
            $display("FAIL conv_strobe_overlap: %0d cycles, required 0", bad_both);
        end
        checks++;
        if (bad_fifo !== 0) begin
            errors++;
            $display("FAIL conv_fifo: %0d bad cycles, required 0", bad_fifo);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        clear_ovf = 1'b0;
        res_if.res_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (clk_init !== 1'b0) begin errors++; $display("FAIL reset_clk_init: got %b required 0", clk_init); end
        checks++;
        if (clk_update !== 1'b0) begin errors++; $display("FAIL reset_clk_update: got %b required 0", clk_update); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++;
        if (res_if.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b required 0", res_if.res_valid); end
        checks++;
        if (res_if.res_data !== 16'h0) begin errors++; $display("FAIL reset_res_data: got %h required 0000", res_if.res_data); end
        checks++;
        if (res_if.res_tag !== 8'h0) begin errors++; $display("FAIL reset_res_tag: got %h required 00", res_if.res_tag); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b required 0", overflow); end
        rst = 1'b0;
        model_reset();
        idle_cycles(3);
    endtask

    task automatic test_single();
        int n;
        do_reset();
        convert(16'hA5C3, 0, 0, 0, 0, n);
        checks++;
        if (n !== NDAC) begin errors++; $display("FAIL single_update_count: got %0d required %0d", n, NDAC); end
        checks++;
        if (res_if.res_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b required 1", res_if.res_valid); end
        checks++;
        if (res_if.res_data !== 16'hA5C3) begin errors++; $display("FAIL single_data: got %h required a5c3", res_if.res_data); end
        checks++;
        if (res_if.res_tag !== 8'h00) begin errors++; $display("FAIL single_tag: got %h required 00", res_if.res_tag); end
        res_if.res_ready = 1'b1;
        idle_cycles(1);
        res_if.res_ready = 1'b0;
        checks++;
        if (res_if.res_valid !== 1'b0) begin errors++; $display("FAIL single_drain: valid %b required 0", res_if.res_valid); end
    endtask

    task automatic test_ignored_start();
        int n;
        convert(NDAC'($urandom), 0, 1, 0, 0, n);
        checks++;
        if (n !== NDAC) begin errors++; $display("FAIL ignored_start_updates: got %0d required %0d", n, NDAC); end
        res_if.res_ready = 1'b1;
        idle_cycles(1);
        res_if.res_ready = 1'b0;
        checks++;
        if (res_if.res_valid !== 1'b0) begin errors++; $display("FAIL ignored_start_entries: valid %b after one pop, required 0", res_if.res_valid); end
    endtask

    task automatic test_overflow();
        int n;
        logic [NDAC-1:0] code;
        do_reset();
        for (int i = 1; i <= 5; i++) convert(NDAC'(i), 0, 0, 0, 0, n);
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b required 1", overflow); end
        res_if.res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({res_if.res_tag, res_if.res_data} !== {8'(i), NDAC'(i + 1)}) begin
                errors++;
                $display("FAIL overflow_drain_%0d: tag/data %h/%h required %h/%h",
                         i, res_if.res_tag, res_if.res_data, 8'(i), NDAC'(i + 1));
            end
            idle_cycles(1);
        end
        res_if.res_ready = 1'b0;
        checks++;
        if (res_if.res_valid !== 1'b0) begin errors++; $display("FAIL overflow_empty: valid %b required 0", res_if.res_valid); end
        code = NDAC'($urandom);
        convert(code, 0, 0, 0, 0, n);
        checks++;
        if (res_if.res_tag !== 8'd5) begin errors++; $display("FAIL overflow_next_tag: got %0d required 5", res_if.res_tag); end
    endtask

    task automatic test_full_pop();
        int n;
        logic [NDAC-1:0] codes [5];
        do_reset();
        for (int i = 0; i < 5; i++) codes[i] = NDAC'($urandom);
        for (int i = 0; i < 4; i++) convert(codes[i], 0, 0, 0, 0, n);
        convert(codes[4], 3, 0, 0, 0, n);
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL full_pop_overflow: got %b required 0", overflow); end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if ({res_if.res_tag, res_if.res_data} !== {8'(i), codes[i]}) begin
                errors++;
                $display("FAIL full_pop_order_%0d: tag/data %h/%h required %h/%h",
                         i, res_if.res_tag, res_if.res_data, 8'(i), codes[i]);
            end
            res_if.res_ready = 1'b1;
            idle_cycles(1);
        end
        res_if.res_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        int rst_pts [2] = '{20, 22};
        logic [NDAC-1:0] code;
        do_reset();
        convert(NDAC'($urandom), 0, 0, 0, 0, n);
        foreach (rst_pts[i]) begin
            convert(NDAC'($urandom), 0, 0, rst_pts[i], 0, n);
            idle_cycles(2);
        end
        code = NDAC'($urandom);
        convert(code, 0, 0, 0, 0, n);
        checks++;
        if (res_if.res_tag !== 8'd0 || res_if.res_data !== code) begin
            errors++;
            $display("FAIL reset_mid_first_entry: tag/data %h/%h required 00/%h", res_if.res_tag, res_if.res_data, code);
        end
        res_if.res_ready = 1'b1;
        idle_cycles(1);
        res_if.res_ready = 1'b0;
    endtask

    task automatic test_clear_ovf();
        int n;
        do_reset();
        for (int i = 0; i < 5; i++) convert(NDAC'($urandom), 0, 0, 0, 0, n);
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL clear_ovf_set: got %b required 1", overflow); end
        convert(NDAC'($urandom), 0, 0, 0, CAP, n);
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL clear_ovf_with_drop: got %b required 1", overflow); end
        clear_ovf = 1'b1;
        idle_cycles(1);
        clear_ovf = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL clear_ovf_alone: got %b required 0", overflow); end
        res_if.res_ready = 1'b1;
        idle_cycles(DEPTH + 1);
        res_if.res_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n;
        do_reset();
        for (int i = 0; i < 3; i++) convert(NDAC'($urandom), 2, 3, 0, 0, n);
        idle_cycles(2);
    endtask

    task automatic test_random();
        int n;
        for (int i = 0; i < 10; i++) begin
            convert(NDAC'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), 0,
                    $urandom_range(0, CAP + 5), n);
            checks++;
            if (n !== NDAC) begin errors++; $display("FAIL random_update_count_%0d: got %0d required %0d", i, n, NDAC); end
        end
        res_if.res_ready = 1'b0;
        idle_cycles(2);
    endtask

    initial begin
        res_if.res_ready = 1'b0;
        test_reset();
        test_single();
        test_ignored_start();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_clear_ovf();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1);
    end
endmodule

// File: doc/sar_sequencer.md
Name: sar_sequencer

Overview:
- Single-clock controller that drives one SAR conversion: generates the clk_init / clk_update strobes for the SAR logic block and captures the final dac_state code.
- Captured codes are buffered in a small FIFO and handed to the readout path (SPI/serializer) over a valid/ready interface.
- Sits between the SPI/readout domain and the SAR logic + comparator.

Parameters:
- Ndac, 16, number of DAC steps; width of the captured code and the number of update strobes per conversion.
- SETTLE, 2, idle cycles (clk_init and clk_update both low) before each clk_update pulse; legal range 1..255.
- DEPTH, 4, result FIFO depth; power of two, ≥2.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  conversion request; sampled only in IDLE.
- clear_ovf  input  1  synchronous clear of the overflow flag.
- dac_state_in  input  Ndac  final code from the SAR logic.
- clk_init  output  1  init strobe to the SAR logic; registered.
- clk_update  output  1  update strobe to the SAR logic; registered.
- busy  output  1  conversion in progress.
- res_data  output  Ndac  FIFO head code.
- res_tag  output  8  conversion index of the head entry.
- res_valid  output  1  FIFO non-empty.
- res_ready  input  1  consumer accepts the head entry.
- overflow  output  1  sticky; a capture found the FIFO full.

Behaviour:
- Reset (async assert, sync release): state IDLE; clk_init=0, clk_update=0, busy=0; FIFO emptied, res_valid=0, res_data=0, res_tag=0; overflow=0; tag counter=0; bit and settle counters=0.
- States: IDLE, INIT, SETTLE, UPDATE, CAPTURE.
  - IDLE: start=1 → INIT. Otherwise stay in IDLE.
  - INIT: clk_init=1 for exactly one cycle; bit counter cleared → SETTLE.
  - SETTLE: both strobes low for SETTLE cycles → UPDATE.
  - UPDATE: clk_update=1 for exactly one cycle; bit counter increments. If the counter reaches Ndac → CAPTURE, else → SETTLE.
  - CAPTURE: both strobes low; dac_state_in sampled this cycle (one full cycle after the last clk_update falls, so the SAR register has settled) → IDLE.
- Timing, with cycle 0 = the edge where start is sampled in IDLE:
  - clk_init high during cycle 1.
  - Update pulse n (n=1..Ndac) high during cycle 1+n·(SETTLE+1).
  - Capture in cycle 2+Ndac·(SETTLE+1).
  - busy high from cycle 1 through the capture cycle inclusive.
- clk_init and clk_update are never high in the same cycle and are glitch-free (driven directly from flops).
- start while busy is ignored (no queueing). start held high continuously re-triggers in the first IDLE cycle after CAPTURE, giving one idle cycle between conversions.
- Capture:
  - Writes {tag, dac_state_in} to the FIFO if not full. Tag counter increments (mod 256) on every capture, written or dropped, so gaps in res_tag reveal drops.
  - If the FIFO is full: data dropped, overflow←1.
  - overflow stays set until clear_ovf or rst. A capture-drop in the same cycle as clear_ovf leaves overflow=1.
- FIFO: first-word fall-through.
  - res_data and res_tag are valid whenever res_valid=1; pop on res_valid & res_ready.
  - Simultaneous push and pop when full: pop succeeds, push is accepted (no drop).
  - Simultaneous push and pop when empty: push lands; res_valid rises next cycle.
  - res_ready while empty: no effect.
  - Pointers wrap modulo DEPTH; occupancy counter width log2(DEPTH)+1.
- Reset mid-conversion: strobes drop immediately (async), the partial conversion is discarded, and no capture occurs.

Test Plan:
- Ndac=16, SETTLE=2, single start pulse, dac_state_in=16'hA5C3 held → clk_init high cycle 1; 16 clk_update pulses at cycles 4,7,…,49; capture at cycle 50; res_valid=1 from cycle 51 with res_data=16'hA5C3, res_tag=0; busy high cycles 1–50.
- start pulsed at cycles 10 and 30 during the conversion above → ignored; exactly 16 update pulses and one FIFO entry.
- res_ready=0, 5 back-to-back conversions with codes 1..5, DEPTH=4 → FIFO holds codes 1–4 with tags 0–3; overflow=1; then drain → tags 0,1,2,3; next conversion stores tag 5.
- FIFO full, res_ready=1 held through the next capture → no drop, overflow stays 0, ordering preserved.
- rst asserted at cycle 20 of a conversion → clk_update/busy low within the same cycle; res_valid=0; after release and a new start, the first entry has tag 0.
- overflow=1, clear_ovf pulsed in the same cycle as a capture-drop → overflow remains 1; clear_ovf pulsed alone → overflow=0 next cycle.
